// File: rtl/uiudp_tx_arb_pkg.sv
// Shared types for the UDP transmit round-robin arbiter.
package uiudp_tx_arb_pkg;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned PORT_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PTR_W  = 3;
  localparam int unsigned MAX_CH = 8;

  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_STREAM    = 3'd3,
    ST_DRAIN     = 3'd4
  } state_e;

  // Per-channel header fields latched at grant time.
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [PORT_W-1:0] local_port;
    logic [PORT_W-1:0] dest_port;
  } ch_hdr_t;

  // Channel index following idx, wrapping at ch_num.
  function automatic ptr_t next_ptr(input ptr_t idx, input int unsigned ch_num);
    return (idx == ptr_t'(ch_num - 1)) ? '0 : ptr_t'(idx + ptr_t'(1));
  endfunction

endpackage

// File: rtl/uiudp_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module uiudp_rr_pick
  import uiudp_tx_arb_pkg::*;
#(
  parameter int unsigned CH_NUM = 4
) (
  input  logic [CH_NUM-1:0] req,
  input  ptr_t              ptr,
  output logic [CH_NUM-1:0] gnt_c,
  output ptr_t              idx_c,
  output logic              any_c
);

  logic [CH_NUM-1:0] ge_mask;
  logic [CH_NUM-1:0] hi_req;
  logic [CH_NUM-1:0] sel_src;

  // Prefer requesters at/above ptr, otherwise wrap to the lowest requester.
  always_comb begin
    ge_mask = ~((CH_NUM'(1) << ptr) - CH_NUM'(1));
    hi_req  = req & ge_mask;
    sel_src = (|hi_req) ? hi_req : req;
    gnt_c   = sel_src & (~sel_src + CH_NUM'(1));
    any_c   = |req;
    idx_c   = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (gnt_c == (CH_NUM'(1) << k)) idx_c = ptr_t'(k);
    end
  end

endmodule

// File: rtl/uiudp_tx_arb.sv
// Round-robin scheduler sharing one UDP transmit port between CH_NUM sources.
module uiudp_tx_arb
  import uiudp_tx_arb_pkg::*;
#(
  parameter int unsigned CH_NUM       = 4,
  parameter logic [15:0] BUSY_TIMEOUT = 16'd1000
) (
  input  logic                   I_W_udp_clk,
  input  logic                   I_reset,
  input  logic [CH_NUM-1:0]      I_ch_req,
  input  logic [16*CH_NUM-1:0]   I_ch_len,
  input  logic [16*CH_NUM-1:0]   I_ch_local_port,
  input  logic [16*CH_NUM-1:0]   I_ch_dest_port,
  input  logic [CH_NUM-1:0]      I_ch_valid,
  input  logic [8*CH_NUM-1:0]    I_ch_data,
  output logic [CH_NUM-1:0]      O_ch_gnt,
  output logic [CH_NUM-1:0]      O_ch_done,
  output logic                   O_udp_req,
  output logic                   O_udp_valid,
  output logic [7:0]             O_udp_data,
  output logic [15:0]            O_udp_len,
  output logic [15:0]            O_udp_local_port,
  output logic [15:0]            O_udp_dest_port,
  input  logic                   I_udp_busy,
  output logic                   O_timeout_err
);

  state_e              state_q, state_d;
  ptr_t                ptr_q, ptr_d;
  ptr_t                idx_q, idx_d;
  ch_hdr_t             hdr_q, hdr_d;
  logic [LEN_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [15:0]         to_cnt_q, to_cnt_d;
  logic [CH_NUM-1:0]   gnt_d, done_d;
  logic                req_d, valid_d, err_d;
  logic [DATA_W-1:0]   data_d;

  ch_hdr_t             hdr_a  [MAX_CH];
  logic [DATA_W-1:0]   data_a [MAX_CH];
  logic [MAX_CH-1:0]   valid_x;

  logic [CH_NUM-1:0]   pick_gnt;
  ptr_t                pick_idx;
  logic                pick_any;

  // Unpack channel buses into fixed-size arrays indexable by a 3-bit pointer.
  for (genvar g = 0; g < MAX_CH; g++) begin : g_ch
    if (g < CH_NUM) begin : g_on
      assign hdr_a[g]   = {I_ch_len[16*g +: 16], I_ch_local_port[16*g +: 16],
                           I_ch_dest_port[16*g +: 16]};
      assign data_a[g]  = I_ch_data[8*g +: 8];
      assign valid_x[g] = I_ch_valid[g];
    end else begin : g_off
      assign hdr_a[g]   = '0;
      assign data_a[g]  = '0;
      assign valid_x[g] = 1'b0;
    end
  end

  uiudp_rr_pick #(.CH_NUM(CH_NUM)) u_pick (
    .req   (I_ch_req),
    .ptr   (ptr_q),
    .gnt_c (pick_gnt),
    .idx_c (pick_idx),
    .any_c (pick_any)
  );

  assign O_udp_len        = hdr_q.len;
  assign O_udp_local_port = hdr_q.local_port;
  assign O_udp_dest_port  = hdr_q.dest_port;

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    hdr_d      = hdr_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    gnt_d      = O_ch_gnt;
    done_d     = '0;
    req_d      = 1'b0;
    valid_d    = 1'b0;
    data_d     = '0;
    err_d      = O_timeout_err;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (!I_udp_busy && pick_any) begin
          idx_d      = pick_idx;
          gnt_d      = pick_gnt;
          hdr_d      = hdr_a[pick_idx];
          byte_cnt_d = '0;
          if (hdr_a[pick_idx].len == '0) begin
            done_d = pick_gnt;
            ptr_d  = next_ptr(pick_idx, CH_NUM);
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        req_d    = 1'b1;
        to_cnt_d = '0;
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (I_udp_busy) begin
          state_d = ST_STREAM;
        end else if (to_cnt_q == BUSY_TIMEOUT - 16'd1) begin
          gnt_d   = '0;
          err_d   = 1'b1;
          done_d  = O_ch_gnt;
          ptr_d   = next_ptr(idx_q, CH_NUM);
          state_d = ST_IDLE;
        end else begin
          req_d    = 1'b1;
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      ST_STREAM: begin
        if (valid_x[idx_q]) begin
          valid_d    = 1'b1;
          data_d     = data_a[idx_q];
          byte_cnt_d = byte_cnt_q + LEN_W'(1);
          if (byte_cnt_q + LEN_W'(1) == hdr_q.len) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!I_udp_busy) begin
          done_d  = O_ch_gnt;
          gnt_d   = '0;
          ptr_d   = next_ptr(idx_q, CH_NUM);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge I_W_udp_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      idx_q         <= '0;
      hdr_q         <= '0;
      byte_cnt_q    <= '0;
      to_cnt_q      <= '0;
      O_ch_gnt      <= '0;
      O_ch_done     <= '0;
      O_udp_req     <= 1'b0;
      O_udp_valid   <= 1'b0;
      O_udp_data    <= '0;
      O_timeout_err <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      hdr_q         <= hdr_d;
      byte_cnt_q    <= byte_cnt_d;
      to_cnt_q      <= to_cnt_d;
      O_ch_gnt      <= gnt_d;
      O_ch_done     <= done_d;
      O_udp_req     <= req_d;
      O_udp_valid   <= valid_d;
      O_udp_data    <= data_d;
      O_timeout_err <= err_d;
    end
  end

endmodule

// File: tb/tb_uiudp_tx_arb.sv
// Bench for uiudp_tx_arb: table of transfers plus hand-written corner sequences.
module tb_uiudp_tx_arb;

  localparam int unsigned CH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    ch_req;
  logic [16*CH-1:0] ch_len, ch_lport, ch_dport;
  logic [CH-1:0]    ch_valid;
  logic [8*CH-1:0]  ch_data;
  logic [CH-1:0]    gnt, done;
  logic             udp_req, udp_valid, busy, terr;
  logic [7:0]       udp_data;
  logic [15:0]      udp_len, lport, dport;

  int          checks = 0;
  int          errors = 0;
  int          rx_cnt = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int          ch;
    logic [15:0] len;
    int          dly;
    logic [7:0]  base;
    logic [3:0]  req_set;
    logic        drop_on_gnt;
    logic        noise;
    logic [3:0]  req_after;
  } vec_t;
  localparam int NV = 7;
  vec_t vt[NV];

  uiudp_tx_arb #(.CH_NUM(CH), .BUSY_TIMEOUT(16'd20)) dut (
    .I_W_udp_clk      (clk),
    .I_reset          (rst),
    .I_ch_req         (ch_req),
    .I_ch_len         (ch_len),
    .I_ch_local_port  (ch_lport),
    .I_ch_dest_port   (ch_dport),
    .I_ch_valid       (ch_valid),
    .I_ch_data        (ch_data),
    .O_ch_gnt         (gnt),
    .O_ch_done        (done),
    .O_udp_req        (udp_req),
    .O_udp_valid      (udp_valid),
    .O_udp_data       (udp_data),
    .O_udp_len        (udp_len),
    .O_udp_local_port (lport),
    .O_udp_dest_port  (dport),
    .I_udp_busy       (busy),
    .O_timeout_err    (terr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {13'd0, gnt, done, udp_req, udp_valid, terr, udp_data}, 32'd0);
    check({name, "_hdr"}, {udp_len, lport}, 32'd0);
    check({name, "_dport"}, {16'd0, dport}, 32'd0);
  endtask

  // Scoreboard: every forwarded byte must match the oldest driven byte, one cycle later.
  task automatic monitor;
    sb_t e;
    forever begin
      @(negedge clk);
      if (udp_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_extra_byte", {24'd0, udp_data}, 32'h100);
        end else begin
          e = sb_q.pop_front();
          check("sb_data", {24'd0, udp_data}, {24'd0, e.data});
          check("sb_latency", cyc, e.cyc + 1);
          rx_cnt++;
        end
      end
    end
  endtask

  // Act as the channel source and the UDP layer for one granted transfer.
  task automatic serve(input int ch, input logic [15:0] len, input int dly,
                       input logic [7:0] base, input logic noise);
    int n;
    rx_cnt = 0;
    n = 0;
    while (!udp_req && n < 10) begin tick; n++; end
    check("req_rise", {31'd0, udp_req}, 32'd1);
    repeat (dly) tick;
    busy = 1'b1;
    n = 0;
    while (udp_req && n < 10) begin tick; n++; end
    check("req_drop_on_busy", {31'd0, udp_req}, 32'd0);
    for (int i = 0; i < int'(len); i++) begin
      ch_valid[ch]          = 1'b1;
      ch_data[ch*8 +: 8]    = 8'(int'(base) + i);
      if (noise) begin
        ch_valid[0]  = 1'b1;
        ch_data[7:0] = 8'hEE;
      end
      sb_q.push_back('{8'(int'(base) + i), cyc});
      tick;
    end
    ch_valid = '0;
    // Overrun byte after len must be blocked.
    ch_valid[ch]       = 1'b1;
    ch_data[ch*8 +: 8] = 8'hEE;
    tick;
    ch_valid = '0;
    repeat (2) tick;
    busy = 1'b0;
    n = 0;
    do begin tick; n++; end while (done[ch] == 1'b0 && n < 10);
    check("done_pulse", {28'd0, done}, 32'd1 << ch);
    check("gnt_clear", {28'd0, gnt}, 32'd0);
    check("len_stable", {16'd0, udp_len}, {16'd0, len});
    check("rx_count", rx_cnt, int'(len));
    check("sb_empty", sb_q.size(), 32'd0);
  endtask

  initial begin
    int n, hi, reqcnt;
    vt[0] = '{0, 16'd4,  1, 8'h10, 4'b1111, 1'b0, 1'b0, 4'b1111};
    vt[1] = '{1, 16'd4,  2, 8'h20, 4'b1111, 1'b0, 1'b0, 4'b1111};
    vt[2] = '{2, 16'd4,  1, 8'h30, 4'b1111, 1'b0, 1'b0, 4'b1111};
    vt[3] = '{3, 16'd4,  2, 8'h40, 4'b1111, 1'b0, 1'b0, 4'b1111};
    vt[4] = '{0, 16'd4,  1, 8'h50, 4'b1111, 1'b0, 1'b0, 4'b0000};
    vt[5] = '{1, 16'd10, 3, 8'h00, 4'b0010, 1'b1, 1'b0, 4'b0000};
    vt[6] = '{3, 16'd6,  2, 8'h60, 4'b1000, 1'b0, 1'b1, 4'b0000};

    rst = 1'b1; busy = 1'b0; ch_req = '0; ch_valid = '0; ch_data = '0;
    for (int k = 0; k < int'(CH); k++) begin
      ch_len[k*16 +: 16]   = 16'd4;
      ch_lport[k*16 +: 16] = 16'(16'h1000 + k);
      ch_dport[k*16 +: 16] = 16'(16'h2000 + 16'h11 * k);
    end
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tick;

    // Table-driven transfers: round robin 0,1,2,3,0 then single-channel cases.
    for (int e = 0; e < NV; e++) begin
      ch_len[vt[e].ch*16 +: 16] = vt[e].len;
      ch_req = vt[e].req_set;
      n = 0;
      do begin tick; n++; end while (gnt == '0 && n < 10);
      check($sformatf("gnt_v%0d", e), {28'd0, gnt}, 32'd1 << vt[e].ch);
      check($sformatf("len_v%0d", e), {16'd0, udp_len}, {16'd0, vt[e].len});
      check($sformatf("lport_v%0d", e), {16'd0, lport}, 32'h1000 + vt[e].ch);
      check($sformatf("dport_v%0d", e), {16'd0, dport}, 32'h2000 + 32'h11 * vt[e].ch);
      check($sformatf("req_late_v%0d", e), {31'd0, udp_req}, 32'd0);
      if (vt[e].drop_on_gnt) ch_req[vt[e].ch] = 1'b0;
      serve(vt[e].ch, vt[e].len, vt[e].dly, vt[e].base, vt[e].noise);
      ch_req = vt[e].req_after;
    end

    // Zero-length request: done pulse, no UDP request.
    tick;
    ch_len[2*16 +: 16] = 16'd0;
    ch_req = 4'b0100;
    tick;
    check("len0_done", {28'd0, done}, 32'h4);
    check("len0_gnt", {28'd0, gnt}, 32'h4);
    ch_req = '0;
    reqcnt = 0;
    tick;
    check("len0_done_single", {28'd0, done}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (udp_req) reqcnt++;
      tick;
    end
    check("len0_no_req", reqcnt, 32'd0);

    // Busy never rises: timeout after 20 cycles, next channel granted.
    ch_len[0 +: 16]  = 16'd5;
    ch_len[16 +: 16] = 16'd5;
    ch_req = 4'b0011;
    tick;
    check("to_gnt", {28'd0, gnt}, 32'h1);
    n = 0;
    while (!udp_req && n < 10) begin tick; n++; end
    hi = 0;
    while (udp_req && hi < 100) begin hi++; tick; end
    check("to_req_cycles", hi, 32'd20);
    check("to_err", {31'd0, terr}, 32'd1);
    check("to_done", {28'd0, done}, 32'h1);
    check("to_gnt_drop", {28'd0, gnt}, 32'd0);
    ch_req = 4'b0010;
    tick;
    check("to_next_gnt", {28'd0, gnt}, 32'h2);
    ch_req = '0;
    serve(1, 16'd5, 1, 8'h70, 1'b0);
    check("to_err_sticky", {31'd0, terr}, 32'd1);

    // Reset midway through a 100-byte stream.
    tick;
    ch_len[2*16 +: 16] = 16'd100;
    ch_req = 4'b0100;
    tick;
    check("rst_gnt", {28'd0, gnt}, 32'h4);
    ch_req = '0;
    n = 0;
    while (!udp_req && n < 10) begin tick; n++; end
    busy = 1'b1;
    n = 0;
    while (udp_req && n < 10) begin tick; n++; end
    for (int i = 0; i < 50; i++) begin
      ch_valid[2]   = 1'b1;
      ch_data[23:16] = 8'(i);
      sb_q.push_back('{8'(i), cyc});
      tick;
    end
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    sb_q.delete();
    ch_valid = '0;
    busy = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    for (int k = 0; k < int'(CH); k++) ch_len[k*16 +: 16] = 16'd3;
    ch_req = 4'b1111;
    tick;
    check("rr_after_reset", {28'd0, gnt}, 32'h1);
    ch_req = '0;
    serve(0, 16'd3, 1, 8'h80, 1'b0);

    repeat (3) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
